mux_scan_ctrl: RTL

Sequencer that sits directly upstream of the pipelined bus multiplexer. It drives the multiplexer's select input and steps through a programmable set of enabled input channels. It waits out the multiplexer's fixed pipeline latency, captures lane 0 of the multiplexer output, and presents each sample tagged with its channel number on a valid/ready stream. Downstream consumers, such as a UART/packet formatter, receive one tagged word per enabled channel per sweep.

---
 rtl/mux_scan_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mux_scan_ctrl.sv
// Channel sequencer ahead of a pipelined bus mux: selects each enabled input,
// waits out the mux latency, and emits channel-tagged samples on a valid/ready stream.
module mux_scan_ctrl #(
  parameter int unsigned NUM_INPUT   = 8,
  parameter int unsigned SEL_BIT     = 3,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MUX_LATENCY = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [NUM_INPUT-1:0]  chan_mask_i,
  output logic [SEL_BIT-1:0]    sel_out_o,
  input  logic [DATA_WIDTH-1:0] mux_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [SEL_BIT-1:0]    m_chan_o,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic [15:0]           sweep_count_o
);

  localparam int unsigned CNT_W = (MUX_LATENCY < 1) ? 1 : $clog2(MUX_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUX_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_OUTPUT = 2'd2
  } state_e;

  state_e                  state_q;
  logic [NUM_INPUT-1:0]    mask_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [SEL_BIT-1:0]      sel_q;
  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [SEL_BIT-1:0]      chan_q;
  logic                    last_q;
  logic                    busy_q;
  logic [15:0]             sweep_q;
  logic [15:0]             sweep_d;

  logic                    first_hit_c;
  logic [SEL_BIT-1:0]      first_chan_c;
  logic                    next_hit_c;
  logic [SEL_BIT-1:0]      next_chan_c;

  // Lowest set bit of the live mask (sweep start) and next set bit above sel in the latched mask.
  always_comb begin
    first_hit_c  = 1'b0;
    first_chan_c = '0;
    next_hit_c   = 1'b0;
    next_chan_c  = '0;
    for (int unsigned i = 0; i < NUM_INPUT; i++) begin
      if (!first_hit_c && chan_mask_i[i]) begin
        first_hit_c  = 1'b1;
        first_chan_c = SEL_BIT'(i);
      end
      if (!next_hit_c && mask_q[i] && (SEL_BIT'(i) > sel_q)) begin
        next_hit_c  = 1'b1;
        next_chan_c = SEL_BIT'(i);
      end
    end
  end

  assign sweep_d = sweep_q + 16'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      sweep_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable_i && first_hit_c) begin
            mask_q  <= chan_mask_i;
            sel_q   <= first_chan_c;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            data_q  <= mux_data_i;
            chan_q  <= sel_q;
            last_q  <= !next_hit_c;
            valid_q <= 1'b1;
            state_q <= S_OUTPUT;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_OUTPUT: begin
          // The handshake edge doubles as the next select update; no extra bubble.
          if (m_ready_i) begin
            valid_q <= 1'b0;
            if (next_hit_c) begin
              sel_q   <= next_chan_c;
              cnt_q   <= CNT_LOAD;
              state_q <= S_SETTLE;
            end else begin
              sweep_q <= sweep_d;
              if (enable_i && first_hit_c) begin
                mask_q  <= chan_mask_i;
                sel_q   <= first_chan_c;
                cnt_q   <= CNT_LOAD;
                state_q <= S_SETTLE;
              end else begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign sel_out_o     = sel_q;
  assign m_valid_o     = valid_q;
  assign m_data_o      = data_q;
  assign m_chan_o      = chan_q;
  assign m_last_o      = last_q;
  assign busy_o        = busy_q;
  assign sweep_count_o = sweep_q;

endmodule
